// File: rtl/reg_scoreboard.sv
// Per-register write-pending scoreboard: counts in-flight writes per destination
// register and stalls ID when a source operand still has a write outstanding.
module reg_scoreboard #(
  parameter int NREG  = 16,
  parameter int CNT_W = 2,
  localparam int IDX_W = $clog2(NREG),
  localparam int INF_W = CNT_W + 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] Rn,
  input  logic [IDX_W-1:0] Rdm,
  input  logic             Two_src,
  input  logic             issue_valid,
  input  logic             issue_wb_en,
  input  logic [IDX_W-1:0] issue_dest,
  input  logic             freeze,
  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_dest,
  output logic             Hazard,
  output logic             issue_ready,
  output logic [NREG-1:0]  pending,
  output logic [INF_W-1:0] inflight,
  output logic             err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Handshake: an issue is accepted on a rising edge where issue_valid and
  // issue_ready are both 1; issue_ready never depends on issue_valid.

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]  pending_q, pending_d;
  logic [INF_W-1:0] inflight_q, inflight_d;
  logic             err_q, err_d;

  logic issue_fire;
  logic retire_hit;
  logic same_reg;

  // Hazard looks only at registered counts, so a retire this cycle is not bypassed.
  assign Hazard = (cnt_q[Rn] != '0) || (Two_src && (cnt_q[Rdm] != '0));

  assign issue_ready = !Hazard && !freeze &&
                       !(issue_wb_en && (cnt_q[issue_dest] == CNT_MAX));

  assign issue_fire = issue_valid && issue_ready && issue_wb_en;
  assign retire_hit = wb_valid && (cnt_q[wb_dest] != '0);
  assign same_reg   = issue_fire && wb_valid && (issue_dest == wb_dest);

  always_comb begin
    cnt_d      = cnt_q;
    inflight_d = inflight_q;
    err_d      = err_q;
    pending_d  = '0;
    // An issue and a retire to one register cancel out, including the zero case.
    if (!same_reg) begin
      if (issue_fire) begin
        cnt_d[issue_dest] = cnt_q[issue_dest] + CNT_W'(1);
        inflight_d        = inflight_d + INF_W'(1);
      end
      if (retire_hit) begin
        cnt_d[wb_dest] = cnt_q[wb_dest] - CNT_W'(1);
        inflight_d     = inflight_d - INF_W'(1);
      end else if (wb_valid) begin
        err_d = 1'b1;
      end
    end
    for (int i = 0; i < NREG; i++) begin
      pending_d[i] = (cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '{default: '0};
      pending_q  <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign pending       = pending_q;
  assign inflight      = inflight_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: inputs change 1 time unit after each rising
// edge, outputs are checked 1 time unit after that.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [3:0]  Rn, Rdm, issue_dest, wb_dest;
  logic        Two_src, issue_valid, issue_wb_en, freeze, wb_valid;
  logic        Hazard, issue_ready, err_underflow;
  logic [15:0] pending;
  logic [5:0]  inflight;

  int n_checks = 0;
  int n_fail   = 0;

  reg_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .Rn(Rn), .Rdm(Rdm), .Two_src(Two_src),
    .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_dest(issue_dest),
    .freeze(freeze), .wb_valid(wb_valid), .wb_dest(wb_dest),
    .Hazard(Hazard), .issue_ready(issue_ready), .pending(pending),
    .inflight(inflight), .err_underflow(err_underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Rn = 4'd0; Rdm = 4'd0; Two_src = 1'b0;
    issue_valid = 1'b0; issue_wb_en = 1'b0; issue_dest = 4'd0;
    freeze = 1'b0; wb_valid = 1'b0; wb_dest = 4'd0;
  endtask

  task automatic issue(input logic [3:0] d);
    issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = d;
  endtask

  task automatic retire(input logic [3:0] d);
    wb_valid = 1'b1; wb_dest = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    Rn    = 4'd5;
    repeat (3) tick();
    #1;
    chk("rst_hazard",   32'(Hazard), 32'd0);
    chk("rst_ready",    32'(issue_ready), 32'd1);
    chk("rst_pending",  32'(pending), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_err",      32'(err_underflow), 32'd0);
    freeze = 1'b1;
    #1;
    chk("rst_ready_freeze", 32'(issue_ready), 32'd0);
    freeze = 1'b0;
    rst_n  = 1'b1;
    tick();

    // RAW stall and release on r3
    idle();
    issue(4'd3);
    #1;
    chk("raw_issue_ready", 32'(issue_ready), 32'd1);
    tick();
    idle();
    Rn = 4'd3;
    #1;
    chk("raw_hazard",   32'(Hazard), 32'd1);
    chk("raw_ready",    32'(issue_ready), 32'd0);
    chk("raw_pending",  32'(pending), 32'h0008);
    chk("raw_inflight", 32'(inflight), 32'd1);
    repeat (3) tick();
    chk("raw_hold", 32'(Hazard), 32'd1);
    retire(4'd3);
    #1;
    chk("raw_no_bypass", 32'(Hazard), 32'd1);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("raw_release",  32'(Hazard), 32'd0);
    chk("raw_inflight0", 32'(inflight), 32'd0);
    chk("raw_pending0", 32'(pending), 32'd0);
    chk("raw_err",      32'(err_underflow), 32'd0);

    // Two_src gating with r7 pending
    idle();
    issue(4'd7);
    tick();
    idle();
    Rn = 4'd2; Rdm = 4'd7; Two_src = 1'b0;
    #1;
    chk("two_src0", 32'(Hazard), 32'd0);
    Two_src = 1'b1;
    #1;
    chk("two_src1", 32'(Hazard), 32'd1);
    issue_valid = 1'b1;
    freeze      = 1'b1;
    #1;
    chk("hazard_indep", 32'(Hazard), 32'd1);
    idle();
    retire(4'd7);
    tick();
    idle();
    #1;
    chk("two_src_drain", 32'(inflight), 32'd0);

    // saturation of r9
    issue(4'd9);
    repeat (3) tick();
    #1;
    chk("sat_inflight", 32'(inflight), 32'd3);
    chk("sat_pending",  32'(pending), 32'h0200);
    chk("sat_ready",    32'(issue_ready), 32'd0);
    tick();
    chk("sat_blocked",  32'(inflight), 32'd3);
    issue_wb_en = 1'b0;
    #1;
    chk("sat_nowb_ready", 32'(issue_ready), 32'd1);
    tick();
    chk("sat_nowb_nochg", 32'(inflight), 32'd3);
    issue_wb_en = 1'b1;
    retire(4'd9);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("sat_ready_after", 32'(issue_ready), 32'd1);
    chk("sat_inflight2",   32'(inflight), 32'd2);

    // freeze blocks issue, retire proceeds
    issue_dest = 4'd1;
    freeze     = 1'b1;
    retire(4'd9);
    #1;
    chk("freeze_ready", 32'(issue_ready), 32'd0);
    tick();
    chk("freeze_inflight", 32'(inflight), 32'd1);
    chk("freeze_pending",  32'(pending), 32'h0200);
    idle();
    retire(4'd9);
    tick();
    idle();
    #1;
    chk("drain_inflight", 32'(inflight), 32'd0);

    // simultaneous issue/retire, same register
    issue(4'd4);
    tick();
    retire(4'd4);
    #1;
    chk("same_ready", 32'(issue_ready), 32'd1);
    tick();
    idle();
    #1;
    chk("same1_inflight", 32'(inflight), 32'd1);
    chk("same1_pending",  32'(pending), 32'h0010);
    retire(4'd4);
    tick();
    issue(4'd4);
    retire(4'd4);
    tick();
    idle();
    #1;
    chk("same0_inflight", 32'(inflight), 32'd0);
    chk("same0_pending",  32'(pending), 32'd0);
    chk("same0_err",      32'(err_underflow), 32'd0);

    // simultaneous issue/retire, different registers
    issue(4'd6);
    tick();
    issue(4'd8);
    retire(4'd6);
    tick();
    idle();
    #1;
    chk("diff_inflight", 32'(inflight), 32'd1);
    chk("diff_pending",  32'(pending), 32'h0100);
    retire(4'd8);
    tick();
    idle();

    // underflow is sticky
    retire(4'd12);
    tick();
    idle();
    #1;
    chk("uf_err",      32'(err_underflow), 32'd1);
    chk("uf_inflight", 32'(inflight), 32'd0);
    tick();
    chk("uf_sticky", 32'(err_underflow), 32'd1);

    // asynchronous reset mid-cycle
    issue(4'd2);
    tick();
    idle();
    Rn = 4'd2;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_err",      32'(err_underflow), 32'd0);
    chk("arst_pending",  32'(pending), 32'd0);
    chk("arst_inflight", 32'(inflight), 32'd0);
    chk("arst_hazard",   32'(Hazard), 32'd0);
    issue(4'd2);
    Rn = 4'd0;
    #1;
    rst_n = 1'b1;
    tick();
    idle();
    #1;
    chk("post_rst_pending",  32'(pending), 32'h0004);
    chk("post_rst_inflight", 32'(inflight), 32'd1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Per-register write-pending scoreboard for the 5-stage ARM pipeline. It records every issued instruction that writes a destination register and clears the entry when that write retires in WB. ID-stage source operands are checked against those entries to produce the stall. It replaces per-stage destination comparison with a counted in-flight record, so stall depth no longer depends on pipeline length.

## Interface
Parameters:
- NREG, 16, number of architectural registers; index width is clog2(NREG) = 4.
- CNT_W, 2, width of each pending counter; MAX = 2^CNT_W - 1 writes in flight per register.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, active-low, asynchronous assert; all state is cleared while low.
- Rn  in  4  first source register of the ID-stage instruction.
- Rdm  in  4  second source register of the ID-stage instruction.
- Two_src  in  1  Rdm is a real source when 1.
- issue_valid  in  1  the ID-stage instruction requests issue this cycle.
- issue_wb_en  in  1  the issuing instruction writes a register.
- issue_dest  in  4  destination of the issuing instruction.
- freeze  in  1  global pipeline freeze (memory wait); blocks issue.
- wb_valid  in  1  a register write retires in WB this cycle.
- wb_dest  in  4  register being written back.
- Hazard  out  1  a source of the ID instruction has a pending write.
- issue_ready  out  1  issue is accepted this cycle when issue_valid is also 1.
- pending  out  NREG  bit i = 1 when counter i is non-zero (registered).
- inflight  out  CNT_W+4  total pending writes across all registers (registered).
- err_underflow  out  1  sticky; a retire was seen for a register with a zero counter.

## Operation
- State: NREG counters cnt[i] of CNT_W bits, the inflight register, and the err_underflow flag.
- Hazard is combinational from current state only: (cnt[Rn] != 0) || (Two_src && cnt[Rdm] != 0).
- No WB bypass: a retire in cycle t does not clear Hazard in cycle t.
- issue_ready = !Hazard && !freeze && !(issue_wb_en && cnt[issue_dest] == MAX).
- Issue is accepted when issue_valid && issue_ready.
- Accepted issue with issue_wb_en = 1 increments cnt[issue_dest].
- Accepted issue with issue_wb_en = 0 changes no state.
- Retire (wb_valid = 1) decrements cnt[wb_dest] if it is non-zero.
- Retire to a zero counter leaves the counter at 0 and sets err_underflow. The flag clears only on reset.
- Issue and retire to the same register in the same cycle leave the counter unchanged, even at 0 or MAX. In that case err_underflow is not set.
- Issue and retire to different registers in the same cycle: both take effect.
- inflight = sum of all counters. It is maintained incrementally: +1 on a counted issue, -1 on a valid retire, net 0 when both occur. It never goes below 0.
- pending and inflight reflect state after the last edge. They do not show the current cycle's issue or retire.

## Timing
- Reset: all cnt = 0, pending = 0, inflight = 0, err_underflow = 0.
- During reset, Hazard = 0 and issue_ready = !freeze.
- Reset asserted mid-operation discards all in-flight records immediately (asynchronous). The first edge after rst_n rises performs normal updates.
- Latency from issue to Hazard visible: 1 cycle. An issue at edge t sets the counter, so the instruction in ID at cycle t+1 sees Hazard.
- Latency from retire to Hazard clear: 1 cycle after the wb_valid edge.
- freeze = 1 forces issue_ready = 0 but retires still proceed.
- Hazard is independent of issue_valid and freeze.

## Test plan
- Reset then idle: rst_n low 3 cycles, Rn = 5 -> Hazard = 0, pending = 0, inflight = 0, issue_ready = 1.
- RAW stall and release:
  - Issue wb_en dest = 3 at cycle 0; next cycle Rn = 3 -> Hazard = 1, issue_ready = 0, pending[3] = 1.
  - wb_valid dest = 3 at cycle 4 -> Hazard = 0 from cycle 5; inflight goes 1 -> 0.
- Two_src gating: cnt[7] = 1, Rn = 2, Rdm = 7.
  - Two_src = 0 -> Hazard = 0.
  - Two_src = 1 -> Hazard = 1.
- Saturation: three issues to dest = 9 (MAX = 3).
  - Fourth issue_valid to dest = 9 with Rn clean -> issue_ready = 0.
  - One retire to 9 -> issue_ready = 1 next cycle.
- Simultaneous events:
  - Issue dest = 4 and retire dest = 4 in the same cycle with cnt[4] = 1 -> cnt[4] stays 1, inflight unchanged.
  - Same with cnt[4] = 0 -> stays 0, err_underflow = 0.
- Underflow and async reset:
  - Retire dest = 12 with cnt[12] = 0 -> err_underflow = 1 and stays 1.
  - Pull rst_n low mid-cycle -> err_underflow, pending and inflight go to 0 before the next edge.
